// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
//   arb_state_e : arbiter FSM state (IDLE, WAIT_I, WAIT_D)
//   owner_e     : which requester owns the outstanding transaction
//   state_owner : maps an FSM state to its owner
//   cnt_width   : width of a saturating counter that must reach max_v
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_I    = 2'd1,
        OWNER_D    = 2'd2
    } owner_e;

    function automatic owner_e state_owner(input arb_state_e s);
        case (s)
            WAIT_I:  return OWNER_I;
            WAIT_D:  return OWNER_D;
            default: return OWNER_NONE;
        endcase
    endfunction

    // A zero maximum would give a zero-width counter; keep at least one bit.
    function automatic int cnt_width(input int max_v);
        return (max_v < 1) ? 1 : $clog2(max_v + 1);
    endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Winner selection with fetch starvation protection.
//   clk, rst    : clock, asynchronous active-high reset
//   i_req       : fetch request pending
//   d_req       : data request pending
//   grant_fire  : the memory accepted the current winner this cycle
//   sel_d       : 1 = data side wins, 0 = fetch side wins
// Data wins by default; once STARVE_MAX data grants have been issued while a
// fetch was waiting, the fetch wins the next arbitration.
module mem_arb_select
    import riscv_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic d_req,
    input  logic grant_fire,
    output logic sel_d
);

    localparam int              CW      = cnt_width(STARVE_MAX);
    localparam logic [CW-1:0]   CNT_MAX = CW'(STARVE_MAX);

    logic [CW-1:0] starve_cnt;
    logic          fetch_starved;

    assign fetch_starved = i_req && (starve_cnt == CNT_MAX);
    assign sel_d         = d_req && !fetch_starved;

    // Counts data grants that bypassed a waiting fetch. Any cycle without a
    // fetch request, or a fetch grant, restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!i_req) begin
            starve_cnt <= '0;
        end else if (grant_fire) begin
            if (!sel_d) begin
                starve_cnt <= '0;
            end else if (starve_cnt != CNT_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-ported memory,
// allowing a single outstanding transaction.
//   clk, rst                      : clock, asynchronous active-high reset
//   i_req, i_addr                 : fetch request
//   i_gnt, i_rvalid, i_rdata      : fetch grant and instruction return
//   d_req, d_we, d_addr, d_wdata  : data request (store when d_we=1)
//   d_gnt, d_rvalid, d_rdata      : data grant and load data / store ack
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_gnt            : memory request channel
//   mem_rvalid, mem_rdata         : memory response channel
//   busy                          : a transaction is outstanding
// Handshake: a request is held stable by its source until x_gnt; x_gnt
// pulses in the cycle mem_req && mem_gnt; exactly one response (mem_rvalid)
// follows, and only a response seen in WAIT_I/WAIT_D is forwarded.
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    arb_state_e state;
    arb_state_e state_next;
    owner_e     owner;
    logic       any_req;
    logic       sel_d;
    logic       grant_fire;
    logic       rsp_fire;

    assign any_req    = i_req | d_req;
    assign owner      = state_owner(state);
    // rst gates everything combinational so outputs stay quiet while held.
    assign grant_fire = !rst && (state == IDLE) && any_req && mem_gnt;
    assign rsp_fire   = !rst && (owner != OWNER_NONE) && mem_rvalid;
    assign busy       = (state != IDLE);

    mem_arb_select #(
        .STARVE_MAX (STARVE_MAX)
    ) u_select (
        .clk        (clk),
        .rst        (rst),
        .i_req      (i_req),
        .d_req      (d_req),
        .grant_fire (grant_fire),
        .sel_d      (sel_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        i_gnt      = 1'b0;
        d_gnt      = 1'b0;
        i_rvalid   = 1'b0;
        d_rvalid   = 1'b0;
        i_rdata    = '0;
        d_rdata    = '0;

        case (state)
            IDLE: begin
                // The winner is re-evaluated every cycle; nothing is latched
                // until the memory accepts it.
                if (!rst && any_req) begin
                    mem_req   = 1'b1;
                    mem_addr  = sel_d ? d_addr : i_addr;
                    mem_we    = sel_d & d_we;
                    mem_wdata = sel_d ? d_wdata : '0;
                end
                if (grant_fire) begin
                    d_gnt      = sel_d;
                    i_gnt      = !sel_d;
                    state_next = sel_d ? WAIT_D : WAIT_I;
                end
            end
            WAIT_I, WAIT_D: begin
                if (rsp_fire) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (rsp_fire && owner == OWNER_I) begin
            i_rvalid = 1'b1;
            i_rdata  = mem_rdata;
        end
        if (rsp_fire && owner == OWNER_D) begin
            d_rvalid = 1'b1;
            d_rdata  = mem_rdata;
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, the maximum consecutive data grants while a fetch is pending.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 i_req  input  1  fetch stage requests an instruction read.
REQ-007 i_addr  input  AW  fetch address.
REQ-008 i_gnt  output  1  fetch request accepted by memory this cycle.
REQ-009 i_rvalid / i_rdata  output  1 / DW  instruction return.
REQ-010 d_req / d_we  input  1 / 1  memory-stage request; write when d_we=1.
REQ-011 d_addr / d_wdata  input  AW / DW  data address and store data.
REQ-012 d_gnt  output  1  data request accepted this cycle.
REQ-013 d_rvalid / d_rdata  output  1 / DW  load data, or store acknowledge.
REQ-014 mem_req / mem_we  output  1 / 1  request to the single-ported memory.
REQ-015 mem_addr / mem_wdata  output  AW / DW  address and write data from the selected requester.
REQ-016 mem_gnt  input  1  memory accepts mem_req this cycle.
REQ-017 mem_rvalid / mem_rdata  input  1 / DW  memory response; read data or write acknowledge.
REQ-018 busy  output  1  a transaction is outstanding.

Function
REQ-019 SHALL implement FSM states IDLE, WAIT_I, WAIT_D.
REQ-020 Outstanding transactions SHALL be limited to one.
REQ-021 In IDLE with any request, SHALL drive mem_req=1 and the winner's address, data and we combinationally.
REQ-022 Winner selection SHALL be as follows:
- d_req wins over i_req.
- Exception: i_req wins when starve_cnt == STARVE_MAX.
REQ-023 On mem_gnt in IDLE, SHALL pulse the winner's gnt in the same cycle.
REQ-024 On that grant, SHALL go to WAIT_I or WAIT_D on the next edge.
REQ-025 Without mem_gnt, SHALL stay in IDLE and assert no gnt.
REQ-026 Winner selection SHALL be re-evaluated every cycle until mem_gnt.
REQ-027 In WAIT_x, mem_req SHALL be 0.
REQ-028 In WAIT_x, on mem_rvalid, SHALL assert x_rvalid=1 for one cycle, with x_rdata=mem_rdata in the same cycle.
REQ-029 After that response, SHALL return to IDLE on the next edge.
REQ-030 A new grant SHALL occur no earlier than the cycle after the response.
REQ-031 Writes SHALL also wait for mem_rvalid; d_rdata is don't-care for writes.
REQ-032 mem_rvalid in IDLE SHALL be ignored, with no rvalid output.
REQ-033 starve_cnt SHALL have width clog2(STARVE_MAX+1).
REQ-034 starve_cnt SHALL increment on each d_gnt while i_req=1.
REQ-035 starve_cnt SHALL clear on i_gnt, or on any cycle with i_req=0.
REQ-036 starve_cnt SHALL saturate at STARVE_MAX.
REQ-037 busy SHALL be 1 exactly in WAIT_I or WAIT_D.
REQ-038 Requesters hold req, addr and data stable until gnt; the arbiter SHALL NOT latch request fields before grant.
REQ-039 i_rvalid and d_rvalid SHALL never be asserted in the same cycle.
REQ-040 i_gnt and d_gnt SHALL never be asserted in the same cycle.

Reset
REQ-041 On rst=1, SHALL asynchronously enter IDLE and clear starve_cnt.
REQ-042 During reset, all outputs SHALL be 0, except data buses, which are don't-care but zero-driven.
REQ-043 Reset mid-transaction SHALL discard the owner; a later mem_rvalid is ignored under REQ-032.
REQ-044 The first grant after reset deassertion SHALL occur no earlier than the first rising edge with rst=0.

Structure
REQ-045 The FSM state enum and owner encoding (NONE/I/D) SHALL live in shared package riscv_pkg.
REQ-046 Selection logic and starve_cnt SHALL be sub-module mem_arb_select.
REQ-047 mem_arb_select inputs SHALL be clk, rst, i_req, d_req, grant_fire.
REQ-048 mem_arb_select output SHALL be sel_d.

Verification
REQ-049 i_req only, addr 0x100, mem_gnt same cycle, mem_rvalid 2 cycles later with 0xDEADBEEF -> i_gnt at cycle 0; i_rvalid with 0xDEADBEEF at cycle 2; busy high cycles 1-2.
REQ-050 i_req and d_req together, d_we=1, addr 0x2000, data 0x55 -> d_gnt first, mem_we=1, mem_wdata=0x55; i_gnt only after d_rvalid.
REQ-051 i_req held while d_req is granted 4 times consecutively, with d_req still high -> 5th grant goes to fetch; starve_cnt then 0.
REQ-052 mem_gnt held low 3 cycles with d_req -> mem_req=1 throughout and no d_gnt; d_gnt coincides with the mem_gnt cycle.
REQ-053 rst pulsed during WAIT_D, then mem_rvalid=1 after release -> no d_rvalid; FSM IDLE; next i_req is served normally.
REQ-054 Random traffic checker -> at most one outstanding transaction; gnts mutually exclusive; every gnt is followed by exactly one matching rvalid.
